// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: word-organised RAM with byte-lane writes,
// configurable data-phase wait states and two-cycle ERROR responses.
module ahb_lite_mem_slave #(
    parameter int unsigned HADDR       = 32,
    parameter int unsigned HDATA       = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             HCLK_i,
    input  logic             HRESET_i,
    input  logic             HSEL_i,
    input  logic [HADDR-1:0] HADDR_i,
    input  logic [1:0]       HTRANS_i,
    input  logic             HWRITE_i,
    input  logic [2:0]       HSIZE_i,
    input  logic [HDATA-1:0] HWDATA_i,
    input  logic             HREADY_i,
    output logic             HREADYOUT_o,
    output logic             HRESP_o,
    output logic [HDATA-1:0] HRDATA_o
);
    localparam int unsigned NB = HDATA / 8;
    localparam int unsigned LW = $clog2(NB);
    localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    off_q, off_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;
    logic [HDATA-1:0] rdata_q, rdata_d;
    logic [HDATA-1:0] mem [MEM_DEPTH];

    logic             rdy, resp;
    logic             accept, acc_err, commit, ld_en;
    logic [IW-1:0]    ld_idx;
    logic [NB-1:0]    lane_q;
    logic             unused_htrans0;

    assign unused_htrans0 = HTRANS_i[0];
    assign accept = HSEL_i && HREADY_i && HTRANS_i[1] && rdy;
    assign commit = (state_q == S_DATA) && write_q;

    always_comb begin
        acc_err = 1'b0;
        if ((HADDR_i >> LW) >= HADDR'(MEM_DEPTH)) acc_err = 1'b1;
        if ((32'd8 << HSIZE_i) > HDATA) acc_err = 1'b1;
        if ((HADDR_i & ((HADDR'(1) << HSIZE_i) - HADDR'(1))) != '0) acc_err = 1'b1;
    end

    // Byte lanes touched by the latched transfer, little-endian.
    always_comb begin
        lane_q = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (b >= 32'(off_q) && b < 32'(off_q) + (32'd1 << size_q)) lane_q[b] = 1'b1;
        end
    end

    always_ff @(posedge HCLK_i) begin
        if (HRESET_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        ld_en   = 1'b0;
        ld_idx  = idx_q;
        unique case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DATA;
                    ld_en   = !write_q;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = HADDR_i[LW +: IW];
                    off_d   = HADDR_i[LW-1:0];
                    size_d  = HSIZE_i;
                    write_d = HWRITE_i && !acc_err;
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                        ld_en   = !HWRITE_i;
                        ld_idx  = HADDR_i[LW +: IW];
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    // A write committing on the same edge as a read load is merged so the read sees it.
    always_comb begin
        rdata_d = rdata_q;
        if (ld_en) begin
            rdata_d = mem[ld_idx];
            if (commit && ld_idx == idx_q) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (lane_q[b]) rdata_d[8*b +: 8] = HWDATA_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK_i) begin
        if (!HRESET_i && commit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (lane_q[b]) mem[idx_q][8*b +: 8] <= HWDATA_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdy  = 1'b1;
        resp = 1'b0;
        unique case (state_q)
            S_WAIT:  rdy = 1'b0;
            S_ERR1: begin
                rdy  = 1'b0;
                resp = 1'b1;
            end
            S_ERR2:  resp = 1'b1;
            default: ;
        endcase
    end

    assign HREADYOUT_o = rdy;
    assign HRESP_o     = resp;
    assign HRDATA_o    = rdata_q;
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a
// three-wait-state instance for wait timing and reset-abandoned writes.
module tb_ahb_lite_mem_slave;
    localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel3;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rd0, rd3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_lite_mem_slave #(.HADDR(32), .HDATA(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(sel0), .HADDR_i(addr), .HTRANS_i(trans),
        .HWRITE_i(wr), .HSIZE_i(size), .HWDATA_i(wdata), .HREADY_i(rdy0),
        .HREADYOUT_o(rdy0), .HRESP_o(resp0), .HRDATA_o(rd0)
    );

    ahb_lite_mem_slave #(.HADDR(32), .HDATA(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(sel3), .HADDR_i(addr), .HTRANS_i(trans),
        .HWRITE_i(wr), .HSIZE_i(size), .HWDATA_i(wdata), .HREADY_i(rdy3),
        .HREADYOUT_o(rdy3), .HRESP_o(resp3), .HRDATA_o(rd3)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_resp;
        logic        c_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic w,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic e_rdy, input logic e_resp, input logic c_rd,
                                input logic [31:0] e_rd);
        vec_t v;
        v.sel = sel; v.tr = tr; v.w = w; v.sz = sz; v.a = a; v.wd = wd;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.c_rd = c_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Counts HREADYOUT-low cycles on the wait-state instance, bounded.
    task automatic count_waits(output int n);
        n = 0;
        while (rdy3 !== 1'b1 && n < 20) begin
            chk("ws3_wait_resp", {31'd0, resp3}, 32'd0);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [1:0] tr, input logic w, input logic [2:0] sz,
                         input logic [31:0] a);
        trans = tr; wr = w; size = sz; addr = a;
    endtask

    initial begin
        int n;

        // Reset with random bus activity.
        rst = 1'b1;
        sel0 = 1'b1; sel3 = 1'b1;
        trans = NSQ; wr = 1'b1; size = 3'd2; addr = 32'h10; wdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_rdy0", i), {31'd0, rdy0}, 32'd1);
            chk($sformatf("rst%0d_resp0", i), {31'd0, resp0}, 32'd0);
            chk($sformatf("rst%0d_rd0", i), rd0, 32'd0);
            chk($sformatf("rst%0d_rdy3", i), {31'd0, rdy3}, 32'd1);
            chk($sformatf("rst%0d_rd3", i), rd3, 32'd0);
            sel0 = 1'($urandom_range(0, 1)); sel3 = 1'($urandom_range(0, 1));
            trans = 2'($urandom_range(0, 3)); wr = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 2)); addr = {$urandom_range(0, 255), 2'b00};
            wdata = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; sel0 = 1'b0; sel3 = 1'b0;
        drive(IDL, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        chk("post_rst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("post_rst_resp0", {31'd0, resp0}, 32'd0);
        chk("post_rst_rd0", rd0, 32'd0);

        // Zero-wait instance vector table; expectations describe the cycle whose inputs are listed.
        vecs.push_back(mk(1, NSQ, 1, 2, 32'h10,  32'h0,        1, 0, 1, 32'h0));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h10,  32'hDEADBEEF, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, NSQ, 1, 2, 32'h20,  32'h0,        1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, NSQ, 1, 0, 32'h21,  32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 1, 1, 32'h22,  32'h0000AA00, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h20,  32'h12340000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 0, 0, 32'h23,  32'h0,        1, 0, 1, 32'h1234AA00));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'h1234AA00));
        vecs.push_back(mk(1, NSQ, 1, 2, 32'h0,   32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, SEQ, 1, 2, 32'h3FC, 32'h55667788, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, BSY, 0, 2, 32'h400, 32'hCAFEF00D, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h3FC, 32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, SEQ, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'h55667788));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h400, 32'h0,        1, 0, 1, 32'h55667788));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        0, 1, 1, 32'h55667788));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 1, 1, 32'h55667788));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 1, 2, 32'h2,   32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'hFFFFFFFF, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 1, 1, 32'h1,   32'hFFFFFFFF, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'hFFFFFFFF, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 0, 3, 32'h8,   32'hFFFFFFFF, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'hFFFFFFFF, 0, 1, 1, 32'h55667788));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h0,   32'hFFFFFFFF, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, NSQ, 1, 0, 32'h3,   32'h0,        1, 0, 1, 32'h55667788));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h99000000, 1, 0, 1, 32'h55667788));
        vecs.push_back(mk(1, NSQ, 0, 2, 32'h0,   32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'h99667788));
        vecs.push_back(mk(0, NSQ, 0, 2, 32'h10,  32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk(1, IDL, 0, 2, 32'h0,   32'h0,        1, 0, 1, 32'h99667788));

        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), {31'd0, rdy0}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_resp", i), {31'd0, resp0}, {31'd0, vecs[i].e_resp});
            if (vecs[i].c_rd) chk($sformatf("v%0d_rdata", i), rd0, vecs[i].e_rd);
            sel0 = vecs[i].sel;
            drive(vecs[i].tr, vecs[i].w, vecs[i].sz, vecs[i].a);
            wdata = vecs[i].wd;
        end

        // Three wait states: write @0x10, pipelined read, write offered during waits.
        @(negedge clk);
        sel0 = 1'b0; sel3 = 1'b1;
        chk("ws3_idle_rdy", {31'd0, rdy3}, 32'd1);
        drive(NSQ, 1'b1, 3'd2, 32'h10); wdata = 32'hDEADBEEF;
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0);
        count_waits(n);
        chk("ws3_wr10_waits", n, 32'd3);
        drive(NSQ, 1'b0, 3'd2, 32'h10);
        @(negedge clk);
        drive(NSQ, 1'b1, 3'd2, 32'h14);
        count_waits(n);
        chk("ws3_rd10_waits", n, 32'd3);
        chk("ws3_rd10_data", rd3, 32'hDEADBEEF);
        chk("ws3_rd10_resp", {31'd0, resp3}, 32'd0);
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0); wdata = 32'h11112222;
        count_waits(n);
        chk("ws3_wr14_waits", n, 32'd3);
        drive(NSQ, 1'b0, 3'd2, 32'h14);
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0);
        count_waits(n);
        chk("ws3_rd14_waits", n, 32'd3);
        chk("ws3_rd14_data", rd3, 32'h11112222);

        // Reset during a write's wait cycle must abandon the write.
        drive(NSQ, 1'b1, 3'd2, 32'h30); wdata = 32'hA5A5A5A5;
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0);
        count_waits(n);
        chk("ws3_wr30_waits", n, 32'd3);
        drive(NSQ, 1'b1, 3'd2, 32'h30);
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0); wdata = 32'h0BADF00D;
        chk("ws3_rstwr_wait", {31'd0, rdy3}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ws3_after_rst_rdy", {31'd0, rdy3}, 32'd1);
        chk("ws3_after_rst_resp", {31'd0, resp3}, 32'd0);
        chk("ws3_after_rst_rd", rd3, 32'd0);
        repeat (4) @(negedge clk);
        chk("ws3_idle_after_rst", {31'd0, rdy3}, 32'd1);
        drive(NSQ, 1'b0, 3'd2, 32'h30);
        @(negedge clk);
        drive(IDL, 1'b0, 3'd2, 32'h0);
        count_waits(n);
        chk("ws3_rd30_waits", n, 32'd3);
        chk("ws3_rd30_data", rd3, 32'hA5A5A5A5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
